// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: shared definitions for the per-pad GPIO configuration block.
// Holds the configuration word width, the bit positions of each pad-control
// field inside the word, and the serial-load state encoding.
package gpio_cfg_pkg;

  localparam int CFG_W        = 10;

  localparam int CFG_MGMT_ENA = 0;
  localparam int CFG_OUTENB   = 1;
  localparam int CFG_HOLDOVER = 2;
  localparam int CFG_INP_DIS  = 3;
  localparam int CFG_IB_MODE  = 4;
  localparam int CFG_ANA_EN   = 5;
  localparam int CFG_ANA_SEL  = 6;
  localparam int CFG_ANA_POL  = 7;
  localparam int CFG_DM_LSB   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2,
    OVER  = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/gpio_cfg_shreg.sv
// gpio_cfg_shreg: serial shift register, saturating bit counter and the
// word-length FSM for one pad's configuration chain.
// The FSM state is a registered decode of the next bit count, so it always
// reflects the count held in r_cnt.
module gpio_cfg_shreg
  import gpio_cfg_pkg::*;
#(
  parameter int SW    = 10,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_shift_en,
  input  logic             i_clear,
  input  logic             i_data,
  output logic [SW-1:0]    o_sreg,
  output logic             o_sdo,
  output cfg_state_t       o_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] SW_CNT  = CNT_W'(SW);

  logic [SW-1:0]    r_sreg;
  logic             r_sdo;
  logic [CNT_W-1:0] r_cnt;
  cfg_state_t       r_state;

  logic [CNT_W-1:0] w_cnt_nxt;
  cfg_state_t       w_state_nxt;

  // Next bit count (cleared by commit/reapply, saturating on shift) and its state decode
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_shift_en && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    w_state_nxt = IDLE;
    if (w_cnt_nxt == '0) begin
      w_state_nxt = IDLE;
    end else if (w_cnt_nxt < SW_CNT) begin
      w_state_nxt = SHIFT;
    end else if (w_cnt_nxt == SW_CNT) begin
      w_state_nxt = ARMED;
    end else begin
      w_state_nxt = OVER;
    end
  end

  // Shift path, counter and FSM state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sreg  <= '0;
      r_sdo   <= 1'b0;
      r_cnt   <= '0;
      r_state <= IDLE;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (i_shift_en && !i_clear) begin
        r_sreg <= {r_sreg[SW-2:0], i_data};
        r_sdo  <= r_sreg[SW-1];
      end
    end
  end

  assign o_sreg  = r_sreg;
  assign o_sdo   = r_sdo;
  assign o_state = r_state;

endmodule

// File: rtl/gpio_config_shift.sv
// gpio_config_shift: per-pad active configuration register. Loads from the
// static gpio_defaults word on reset or reapply, accepts a new word through
// the daisy-chained serial path on commit, and decodes the pad-control fields.
// Optional build macro: GPIO_CFG_PARITY_EN (adds a trailing even-parity bit
// to the serial frame and a sticky par_err flag).
module gpio_config_shift #(
  parameter int CFG_W = gpio_cfg_pkg::CFG_W,
  parameter int CNT_W = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [CFG_W-1:0] gpio_defaults,
  input  logic             defaults_reapply,
  input  logic             serial_clock_en,
  input  logic             serial_data_in,
  input  logic             serial_load,
  output logic             serial_data_out,
  output logic [CFG_W-1:0] cfg_q,
  output logic             mgmt_ena,
  output logic             gpio_outenb,
  output logic             gpio_holdover,
  output logic             gpio_inp_dis,
  output logic             gpio_ib_mode_sel,
  output logic             gpio_ana_en,
  output logic             gpio_ana_sel,
  output logic             gpio_ana_pol,
  output logic [1:0]       gpio_dm,
  output logic             load_done,
  output logic             len_err,
  output logic             par_err
);

  import gpio_cfg_pkg::*;

`ifdef GPIO_CFG_PARITY_EN
  localparam int SW = CFG_W + 1;
`else
  localparam int SW = CFG_W;
`endif

  logic [SW-1:0] w_sreg;
  cfg_state_t    w_state;
  logic          w_shift_en;
  logic          w_clear;
  logic          w_par_ok;

  logic [CFG_W-1:0] r_cfg;
  logic             r_load_done;
  logic             r_len_err;

  // Reapply and commit both win over a shift strobe in the same cycle
  assign w_clear    = serial_load | defaults_reapply;
  assign w_shift_en = serial_clock_en & ~w_clear;

  gpio_cfg_shreg #(
    .SW    (SW),
    .CNT_W (CNT_W)
  ) u_shreg (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_shift_en (w_shift_en),
    .i_clear    (w_clear),
    .i_data     (serial_data_in),
    .o_sreg     (w_sreg),
    .o_sdo      (serial_data_out),
    .o_state    (w_state)
  );

`ifdef GPIO_CFG_PARITY_EN
  logic r_par_err;

  // Data bits plus trailing parity bit must hold an even number of ones
  assign w_par_ok = ~(^w_sreg);

  // Sticky parity flag: set by an armed commit with bad parity, cleared by reapply
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_par_err <= 1'b0;
    end else if (defaults_reapply) begin
      r_par_err <= 1'b0;
    end else if (serial_load && (w_state == ARMED) && !w_par_ok) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`else
  assign w_par_ok = 1'b1;
  assign par_err  = 1'b0;
`endif

  // Active config register, commit pulse and sticky length-error flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cfg       <= gpio_defaults;
      r_load_done <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      if (defaults_reapply) begin
        r_cfg     <= gpio_defaults;
        r_len_err <= 1'b0;
      end else if (serial_load) begin
        if (w_state == ARMED) begin
          if (w_par_ok) begin
            r_cfg       <= w_sreg[SW-1 -: CFG_W];
            r_load_done <= 1'b1;
          end
        end else begin
          r_len_err <= 1'b1;
        end
      end
    end
  end

  assign cfg_q     = r_cfg;
  assign load_done = r_load_done;
  assign len_err   = r_len_err;

  assign mgmt_ena         = r_cfg[CFG_MGMT_ENA];
  assign gpio_outenb      = r_cfg[CFG_OUTENB];
  assign gpio_holdover    = r_cfg[CFG_HOLDOVER];
  assign gpio_inp_dis     = r_cfg[CFG_INP_DIS];
  assign gpio_ib_mode_sel = r_cfg[CFG_IB_MODE];
  assign gpio_ana_en      = r_cfg[CFG_ANA_EN];
  assign gpio_ana_sel     = r_cfg[CFG_ANA_SEL];
  assign gpio_ana_pol     = r_cfg[CFG_ANA_POL];
  assign gpio_dm          = r_cfg[CFG_DM_LSB +: 2];

endmodule

// File: tb/tb_gpio_config_shift.sv
// tb_gpio_config_shift: directed stimulus with a scoreboard queue. Each
// stimulus cycle pushes the expected outputs; a negedge monitor pops and
// compares them against the DUT.
module tb_gpio_config_shift;

  localparam int CFG_W = 10;
`ifdef GPIO_CFG_PARITY_EN
  localparam int SW = CFG_W + 1;
`else
  localparam int SW = CFG_W;
`endif

  logic             clk = 1'b0;
  logic             wb_rst_i = 1'b0;
  logic [CFG_W-1:0] gpio_defaults = '0;
  logic             defaults_reapply = 1'b0;
  logic             serial_clock_en = 1'b0;
  logic             serial_data_in = 1'b0;
  logic             serial_load = 1'b0;
  logic             serial_data_out;
  logic [CFG_W-1:0] cfg_q;
  logic             mgmt_ena, gpio_outenb, gpio_holdover, gpio_inp_dis;
  logic             gpio_ib_mode_sel, gpio_ana_en, gpio_ana_sel, gpio_ana_pol;
  logic [1:0]       gpio_dm;
  logic             load_done, len_err, par_err;

  always #5 clk = ~clk;

  gpio_config_shift #(
    .CFG_W (CFG_W),
    .CNT_W (4)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (wb_rst_i),
    .gpio_defaults    (gpio_defaults),
    .defaults_reapply (defaults_reapply),
    .serial_clock_en  (serial_clock_en),
    .serial_data_in   (serial_data_in),
    .serial_load      (serial_load),
    .serial_data_out  (serial_data_out),
    .cfg_q            (cfg_q),
    .mgmt_ena         (mgmt_ena),
    .gpio_outenb      (gpio_outenb),
    .gpio_holdover    (gpio_holdover),
    .gpio_inp_dis     (gpio_inp_dis),
    .gpio_ib_mode_sel (gpio_ib_mode_sel),
    .gpio_ana_en      (gpio_ana_en),
    .gpio_ana_sel     (gpio_ana_sel),
    .gpio_ana_pol     (gpio_ana_pol),
    .gpio_dm          (gpio_dm),
    .load_done        (load_done),
    .len_err          (len_err),
    .par_err          (par_err)
  );

  typedef struct packed {
    logic [CFG_W-1:0] cfg;
    logic             ld;
    logic             len;
    logic             par;
    logic             sdo;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Expected-state bookkeeping: cfg/flags set by hand in the sequence,
  // the serial path tracked as a plain shift model
  logic [CFG_W-1:0] e_cfg = '0;
  logic             e_len = 1'b0;
  logic             e_par = 1'b0;
  logic [SW-1:0]    m_sreg = '0;
  logic             m_sdo  = 1'b0;

  function automatic logic [15:0] frame(input logic [CFG_W-1:0] w);
`ifdef GPIO_CFG_PARITY_EN
    return {5'b0, w, ^w};
`else
    return {6'b0, w};
`endif
  endfunction

  task automatic tick(input logic rst, input logic reap, input logic sce,
                      input logic sdi, input logic sld, input logic ld_exp);
    exp_t e;
    wb_rst_i         = rst;
    defaults_reapply = reap;
    serial_clock_en  = sce;
    serial_data_in   = sdi;
    serial_load      = sld;
    @(posedge clk);
    #1;
    if (rst) begin
      m_sreg = '0;
      m_sdo  = 1'b0;
    end else if (!reap && !sld && sce) begin
      m_sdo  = m_sreg[SW-1];
      m_sreg = {m_sreg[SW-2:0], sdi};
    end
    e.cfg = e_cfg;
    e.ld  = ld_exp;
    e.len = e_len;
    e.par = e_par;
    e.sdo = m_sdo;
    q.push_back(e);
    wb_rst_i         = 1'b0;
    defaults_reapply = 1'b0;
    serial_clock_en  = 1'b0;
    serial_data_in   = 1'b0;
    serial_load      = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tick(1'b0, 1'b0, 1'b1, bits[i], 1'b0, 1'b0);
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare registered outputs and decoded fields each sampled cycle
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    logic [CFG_W-1:0] dec;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.cfg = cfg_q;
      a.ld  = load_done;
      a.len = len_err;
      a.par = par_err;
      a.sdo = serial_data_out;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t: cfg=%h ld=%b len=%b par=%b sdo=%b, required cfg=%h ld=%b len=%b par=%b sdo=%b",
                 $time, a.cfg, a.ld, a.len, a.par, a.sdo, e.cfg, e.ld, e.len, e.par, e.sdo);
      end
      dec = {gpio_dm, gpio_ana_pol, gpio_ana_sel, gpio_ana_en, gpio_ib_mode_sel,
             gpio_inp_dis, gpio_holdover, gpio_outenb, mgmt_ena};
      total++;
      if (dec !== e.cfg) begin
        bad++;
        $display("FAIL decode t=%0t: fields=%h required=%h", $time, dec, e.cfg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset loads defaults, all flags clear
    gpio_defaults = 10'h007;
    e_cfg = 10'h007; e_len = 1'b0; e_par = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Clean commit of 10'h2A5
    shift_bits(frame(10'h2A5), SW);
    e_cfg = 10'h2A5;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    idle();

    // Back to defaults
    e_cfg = 10'h007;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Short word -> len_err, no update
    shift_bits(16'h0155, SW - 1);
    e_len = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Over-long word -> len_err stays, no update
    shift_bits(16'h0ABC, SW + 2);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Commit coincident with a strobe: commit wins, strobe bit dropped
    shift_bits(frame(10'h155), SW);
    e_cfg = 10'h155;
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    shift_bits(16'h0000, 3);

    // Reapply with load in the same cycle: reapply wins, len_err cleared
    e_cfg = 10'h007;
    e_len = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Reset after 5 strobes discards the partial word
    shift_bits(16'h001F, 5);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_bits(frame(10'h2A5), SW);
    e_cfg = 10'h2A5;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();

    // Defaults only sampled on reapply
    gpio_defaults = 10'h3FF;
    idle();
    idle();
    e_cfg = 10'h3FF;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

`ifdef GPIO_CFG_PARITY_EN
    // Bad parity: no update, sticky par_err, no load_done
    shift_bits(frame(10'h2A5) ^ 16'h0001, SW);
    e_par = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    e_par = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
`endif

    repeat (4) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
